// File: rtl/spike_window_counter.sv
// spike_window_counter
// Counts spike events over fixed windows of enabled clock cycles and tracks
// the minimum inter-spike interval (ISI) inside each window. One result per
// window is offered on a valid/ready port. A result that arrives while the
// previous one is still held is discarded and counted in drop_cnt.
//
// Build option: define SPIKE_EDGE_EN to count rising edges of spike instead
// of every enabled cycle with spike high.

module spike_window_counter #(
    parameter int WINDOW_LEN = 256,
    parameter int CNT_W      = 8,
    parameter int ISI_W      = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             spike,
    input  logic             enable,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [ISI_W-1:0] out_isi_min,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int               WIN_W    = (WINDOW_LEN > 2) ? $clog2(WINDOW_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [ISI_W-1:0] ISI_MAX  = '1;

    logic [WIN_W-1:0] win_cnt;
    logic [CNT_W-1:0] acc;
    logic [ISI_W-1:0] gap;
    logic [ISI_W-1:0] min_isi;
    logic             have_prev;

    logic             spike_event;
    logic             win_last;
    logic [ISI_W-1:0] gap_inc;
    logic [CNT_W-1:0] acc_next;
    logic [ISI_W-1:0] min_next;
    logic             load;
    logic             transfer;

`ifdef SPIKE_EDGE_EN
    logic spike_d;

    // Edge register samples spike every cycle, even while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) spike_d <= 1'b0;
        else          spike_d <= spike;
    end

    assign spike_event = enable & spike & ~spike_d;
`else
    assign spike_event = enable & spike;
`endif

    // Per-cycle window arithmetic: saturating ISI and the result including
    // this cycle's event, so the closing cycle's event lands in its window.
    always_comb begin
        win_last = enable && (win_cnt == WIN_LAST);
        gap_inc  = (gap == ISI_MAX) ? ISI_MAX : gap + 1'b1;
        acc_next = acc;
        if (spike_event && (acc != CNT_MAX)) acc_next = acc + 1'b1;
        min_next = min_isi;
        if (spike_event && have_prev && (gap_inc < min_isi)) min_next = gap_inc;
        transfer = out_valid & out_ready;
        load     = win_last & (~out_valid | out_ready);
    end

    // Window timer and running statistics; everything reinitialises on close
    // so an ISI never spans two windows.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt   <= '0;
            acc       <= '0;
            gap       <= '0;
            have_prev <= 1'b0;
            min_isi   <= ISI_MAX;
        end else if (enable) begin
            if (win_last) begin
                win_cnt   <= '0;
                acc       <= '0;
                gap       <= '0;
                have_prev <= 1'b0;
                min_isi   <= ISI_MAX;
            end else begin
                win_cnt <= win_cnt + 1'b1;
                acc     <= acc_next;
                min_isi <= min_next;
                if (spike_event) begin
                    gap       <= '0;
                    have_prev <= 1'b1;
                end else begin
                    gap <= gap_inc;
                end
            end
        end
    end

    // Output holding register with valid/ready handshake and drop counting.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid   <= 1'b0;
            out_count   <= '0;
            out_isi_min <= '0;
            drop_cnt    <= '0;
        end else begin
            if (load) begin
                out_valid   <= 1'b1;
                out_count   <= acc_next;
                out_isi_min <= min_next;
            end else if (transfer) begin
                out_valid <= 1'b0;
            end
            if (win_last && !load && (drop_cnt != CNT_MAX)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spike_window_counter.sv
// Testbench for spike_window_counter: directed windows plus random traffic,
// expected window results from a list-of-event-positions reference model,
// compared by an independent output monitor.

module tb_spike_window_counter;

    localparam int WIN  = 24;
    localparam int CW   = 4;
    localparam int IW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam int IMAX = (1 << IW) - 1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spike = 1'b0;
    logic          enable = 1'b0;
    logic          out_ready = 1'b0;
    logic          out_valid;
    logic [CW-1:0] out_count;
    logic [IW-1:0] out_isi_min;
    logic [CW-1:0] drop_cnt;

    typedef struct {
        int cnt;
        int isi;
    } res_t;

    res_t exp_q[$];
    int   ev_q[$];
    int   m_idx;
    int   m_drops;
    bit   m_held;
`ifdef SPIKE_EDGE_EN
    bit   m_prev;
`endif
    int   n_checks = 0;
    int   n_pass = 0;

    spike_window_counter #(
        .WINDOW_LEN(WIN),
        .CNT_W     (CW),
        .ISI_W     (IW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .spike      (spike),
        .enable     (enable),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_count  (out_count),
        .out_isi_min(out_isi_min),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Window result from the list of event positions (enabled-cycle indices).
    function automatic res_t window_result();
        res_t r;
        int   d;
        r.cnt = (ev_q.size() > CMAX) ? CMAX : ev_q.size();
        r.isi = IMAX;
        for (int k = 1; k < ev_q.size(); k++) begin
            d = ev_q[k] - ev_q[k-1];
            if (d > IMAX) d = IMAX;
            if (d < r.isi) r.isi = d;
        end
        return r;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        ev_q.delete();
        m_idx   = 0;
        m_drops = 0;
        m_held  = 1'b0;
`ifdef SPIKE_EDGE_EN
        m_prev  = 1'b0;
`endif
    endtask

    // Apply the effect of one clock cycle with these inputs to the model.
    task automatic model_cycle(input bit s, input bit e, input bit r);
        bit   ev;
        bit   closing;
        res_t res;
`ifdef SPIKE_EDGE_EN
        ev     = e && s && !m_prev;
        m_prev = s;
`else
        ev     = e && s;
`endif
        closing = e && (m_idx == WIN - 1);
        if (ev) ev_q.push_back(m_idx);
        if (closing) begin
            res = window_result();
            ev_q.delete();
            m_idx = 0;
            if (!m_held || r) begin
                exp_q.push_back(res);
                m_held = 1'b1;
            end else if (m_drops < CMAX) begin
                m_drops++;
            end
        end else begin
            if (e) m_idx++;
            if (m_held && r) m_held = 1'b0;
        end
    endtask

    task automatic step(input bit s, input bit e, input bit r);
        spike     = s;
        enable    = e;
        out_ready = r;
        model_cycle(s, e, r);
        @(posedge clk);
        #1;
    endtask

    task automatic run_window(input logic [WIN-1:0] pat, input bit r);
        for (int i = 0; i < WIN; i++) step(pat[i], 1'b1, r);
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        spike     = 1'b0;
        enable    = 1'b0;
        out_ready = 1'b0;
        model_clear();
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_count", out_count, 0);
        chk("reset_out_isi_min", out_isi_min, 0);
        chk("reset_drop_cnt", drop_cnt, 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: whenever a result is presented it must match the oldest
    // expected result; it is retired when the sink accepts it.
    always @(negedge clk) begin
        if (reset_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got count %0d isi %0d, expected no result",
                         out_count, out_isi_min);
            end else begin
                chk("out_count", out_count, exp_q[0].cnt);
                chk("out_isi_min", out_isi_min, exp_q[0].isi);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dens;
        #1;
        apply_reset();

        // Directed windows with the sink always ready.
        run_window(24'h000188, 1'b1);   // events at 3, 7, 8
        run_window(24'h000000, 1'b1);   // no events
        run_window(24'h000020, 1'b1);   // single event at 5
        run_window(24'h100001, 1'b1);   // ISI of 20 saturates
        run_window(24'hFFFFFF, 1'b1);   // count saturates
        step(1'b0, 1'b0, 1'b1);
        chk("drop_after_ready_windows", drop_cnt, 0);

        // Back-pressure: three windows unaccepted, then the sink returns.
        for (int w = 0; w < 3; w++) run_window(24'h0A0A0A, 1'b0);
        chk("drop_cnt_backpressure", drop_cnt, m_drops);
        chk("drop_cnt_two", m_drops, 2);
        run_window(24'h000000, 1'b1);
        chk("drop_cnt_after_release", drop_cnt, m_drops);
        step(1'b0, 1'b0, 1'b1);

        // Drop counter saturation.
        for (int w = 0; w < 18; w++) run_window(24'h000401, 1'b0);
        chk("drop_cnt_saturated", drop_cnt, m_drops);
        chk("drop_model_saturated", m_drops, CMAX);

        // Mid-window reset at window cycle 9 with four events accumulated.
        apply_reset();
        for (int i = 0; i < 9; i++) step(i[0], 1'b1, 1'b1);
        apply_reset();

        // Five disabled cycles delay the close by exactly five cycles.
        for (int i = 0; i < WIN + 5; i++) begin
            chk("no_close_yet", out_valid, 0);
            step((i % 6) == 2, !(i >= 4 && i < 9), 1'b0);
        end
        chk("close_after_gap", out_valid, 1);

        // Random traffic.
        dens = 1;
        for (int i = 0; i < 1200; i++) begin
            if ((i % 30) == 0) dens = $urandom_range(0, 3);
            step($urandom_range(0, 3) < dens + (dens == 3 ? 1 : 0),
                 $urandom_range(0, 7) != 0,
                 $urandom_range(0, 2) != 0);
        end

        // Drain and final consistency.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_drop_cnt", drop_cnt, m_drops);
        chk("final_valid_low", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
